// File: rtl/eq_coeff_pkg.sv
// Shared defaults and FSM state type for the double-buffered coefficient store.
package eq_coeff_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 64;

  // IDLE accepts writes; PENDING waits for a sample boundary; SWAP flips banks;
  // COPY re-seeds the new shadow from the new active bank.
  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SWAP,
    COPY
  } state_e;

endpackage

// File: rtl/coeff_bank.sv
// One coefficient bank: DEPTH x DATA_W register file, async reset to 0,
// one write port and two combinational read ports. Out-of-range reads return 0
// and out-of-range writes are dropped.
module coeff_bank #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage: cleared on reset, single write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else if (i_we && (32'(i_waddr) < DEPTH)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (32'(i_raddr_a) < DEPTH) ? r_mem[i_raddr_a] : '0;
  assign o_rdata_b = (32'(i_raddr_b) < DEPTH) ? r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/coeff_bank_ctrl.sv
// Double-buffered coefficient store. Host writes land in the shadow bank; after
// write_done the banks swap at the next sample boundary, then the new shadow is
// re-seeded from the active set one entry per enabled cycle.
// Optional feature: define COEFF_READBACK_EN to add a registered shadow readback
// port (i_rb_address / o_rb_coeff).
module coeff_bank_ctrl
  import eq_coeff_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_enable,
  input  logic              i_write_enable,
  input  logic              i_write_done,
  input  logic [ADDR_W-1:0] i_write_address,
  input  logic [DATA_W-1:0] i_coeffs_in,
  input  logic              i_sample_bound,
  input  logic [ADDR_W-1:0] i_rd_address,
`ifdef COEFF_READBACK_EN
  input  logic [ADDR_W-1:0] i_rb_address,
  output logic [DATA_W-1:0] o_rb_coeff,
`endif
  output logic [DATA_W-1:0] o_rd_coeff,
  output logic              o_bank_sel,
  output logic              o_busy,
  output logic              o_swap_done,
  output logic              o_write_err
);

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;
  logic              r_bank_sel, w_bank_sel_next;
  logic [DATA_W-1:0] r_rd_coeff;
  logic              r_write_err, w_err_set;
  logic              w_shadow_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_in_range;
  logic              w_rd_bank;
  logic              w_we0, w_we1;
  logic [ADDR_W-1:0] w_addr_b0, w_addr_b1, w_rb_addr;
  logic [DATA_W-1:0] w_rd_a0, w_rd_a1, w_rd_b0, w_rd_b1;
  logic [DATA_W-1:0] w_copy_src;

  assign w_wr_in_range = (32'(i_write_address) < DEPTH);

  // Only the shadow bank (the one not selected) is ever written.
  assign w_we0 = clk_enable & w_shadow_we & r_bank_sel;
  assign w_we1 = clk_enable & w_shadow_we & ~r_bank_sel;

`ifdef COEFF_READBACK_EN
  assign w_rb_addr = i_rb_address;
`else
  assign w_rb_addr = r_cnt;
`endif

  // Port B: active bank feeds the copy source, shadow bank feeds readback.
  assign w_addr_b0  = r_bank_sel ? w_rb_addr : r_cnt;
  assign w_addr_b1  = r_bank_sel ? r_cnt : w_rb_addr;
  assign w_copy_src = r_bank_sel ? w_rd_b1 : w_rd_b0;

  // On the swap cycle the filter already reads the bank that is becoming active.
  assign w_rd_bank = (r_state == SWAP) ? ~r_bank_sel : r_bank_sel;

  coeff_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bank0 (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we0),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (i_rd_address),
    .o_rdata_a (w_rd_a0),
    .i_raddr_b (w_addr_b0),
    .o_rdata_b (w_rd_b0)
  );

  coeff_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bank1 (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we1),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (i_rd_address),
    .o_rdata_a (w_rd_a1),
    .i_raddr_b (w_addr_b1),
    .o_rdata_b (w_rd_b1)
  );

  // Next-state, shadow write steering and error detection.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_bank_sel_next = r_bank_sel;
    w_err_set       = 1'b0;
    w_shadow_we     = 1'b0;
    w_waddr         = i_write_address;
    w_wdata         = i_coeffs_in;
    unique case (r_state)
      IDLE: begin
        if (i_write_enable) begin
          if (w_wr_in_range) w_shadow_we = 1'b1;
          else               w_err_set   = 1'b1;
        end
        // A bound arriving with write_done is ignored: swap waits for the next one.
        if (i_write_done) w_state_next = PENDING;
      end
      PENDING: begin
        w_err_set = i_write_enable;
        if (i_sample_bound) w_state_next = SWAP;
      end
      SWAP: begin
        w_err_set       = i_write_enable;
        w_bank_sel_next = ~r_bank_sel;
        w_cnt_next      = '0;
        w_state_next    = COPY;
      end
      COPY: begin
        w_err_set   = i_write_enable;
        w_shadow_we = 1'b1;
        w_waddr     = r_cnt;
        w_wdata     = w_copy_src;
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Control state, registered read data and sticky error; frozen when clk_enable=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bank_sel  <= 1'b0;
      r_rd_coeff  <= '0;
      r_write_err <= 1'b0;
    end else if (clk_enable) begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bank_sel  <= w_bank_sel_next;
      r_rd_coeff  <= w_rd_bank ? w_rd_a1 : w_rd_a0;
      r_write_err <= r_write_err | w_err_set;
    end
  end

`ifdef COEFF_READBACK_EN
  logic [DATA_W-1:0] r_rb_coeff;

  // Registered shadow readback for host verification before write_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_rb_coeff <= '0;
    else if (clk_enable) r_rb_coeff <= r_bank_sel ? w_rd_b0 : w_rd_b1;
  end

  assign o_rb_coeff = r_rb_coeff;
`endif

  assign o_rd_coeff  = r_rd_coeff;
  assign o_bank_sel  = r_bank_sel;
  assign o_busy      = (r_state != IDLE);
  assign o_swap_done = (r_state == SWAP);
  assign o_write_err = r_write_err;

endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// Randomized bench for coeff_bank_ctrl against a behavioural bank/phase model.
// Runs with DEPTH=48 so that addresses 48..63 exercise the out-of-range path.
module tb_coeff_bank_ctrl;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 48;

  localparam int PH_IDLE = 0;
  localparam int PH_PEND = 1;
  localparam int PH_SWAP = 2;
  localparam int PH_COPY = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_enable = 1'b0;
  logic          write_enable = 1'b0;
  logic          write_done = 1'b0;
  logic [AW-1:0] write_address = '0;
  logic [DW-1:0] coeffs_in = '0;
  logic          sample_bound = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic [DW-1:0] rd_coeff;
  logic          bank_sel, busy, swap_done, write_err;
`ifdef COEFF_READBACK_EN
  logic [AW-1:0] rb_address = '0;
  logic [DW-1:0] rb_coeff;
`endif

  coeff_bank_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .clk_enable      (clk_enable),
    .i_write_enable  (write_enable),
    .i_write_done    (write_done),
    .i_write_address (write_address),
    .i_coeffs_in     (coeffs_in),
    .i_sample_bound  (sample_bound),
    .i_rd_address    (rd_address),
`ifdef COEFF_READBACK_EN
    .i_rb_address    (rb_address),
    .o_rb_coeff      (rb_coeff),
`endif
    .o_rd_coeff      (rd_coeff),
    .o_bank_sel      (bank_sel),
    .o_busy          (busy),
    .o_swap_done     (swap_done),
    .o_write_err     (write_err)
  );

  always #5 clk = ~clk;

  // Reference model: two arrays, which one the filter sees, and the update phase.
  logic [DW-1:0] m_bank [2][DEPTH];
  int            m_sel;
  int            m_phase;
  int            m_copy_i;
  bit            m_err;
  logic [DW-1:0] m_rd, m_rb;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) m_bank[b][i] = '0;
    m_sel = 0; m_phase = PH_IDLE; m_copy_i = 0; m_err = 0; m_rd = '0; m_rb = '0;
  endtask

  task automatic model_step(input bit we, input bit done, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input bit bnd,
                            input logic [AW-1:0] ra, input logic [AW-1:0] rba);
    int src;
    logic [DW-1:0] nrd, nrb;
    src = (m_phase == PH_SWAP) ? 1 - m_sel : m_sel;
    nrd = (int'(ra) < DEPTH) ? m_bank[src][ra] : '0;
    nrb = (int'(rba) < DEPTH) ? m_bank[1 - m_sel][rba] : '0;
    case (m_phase)
      PH_IDLE: begin
        if (we) begin
          if (int'(wa) < DEPTH) m_bank[1 - m_sel][wa] = wd;
          else m_err = 1;
        end
        if (done) m_phase = PH_PEND;
      end
      PH_PEND: begin
        if (we) m_err = 1;
        if (bnd) m_phase = PH_SWAP;
      end
      PH_SWAP: begin
        if (we) m_err = 1;
        m_sel = 1 - m_sel;
        m_copy_i = 0;
        m_phase = PH_COPY;
      end
      default: begin
        if (we) m_err = 1;
        m_bank[1 - m_sel][m_copy_i] = m_bank[m_sel][m_copy_i];
        m_copy_i++;
        if (m_copy_i == DEPTH) m_phase = PH_IDLE;
      end
    endcase
    m_rd = nrd;
    m_rb = nrb;
  endtask

  task automatic check_outputs();
    check("rd_coeff", rd_coeff, m_rd);
    check("bank_sel", bank_sel, m_sel[0]);
    check("busy", busy, m_phase != PH_IDLE);
    check("swap_done", swap_done, m_phase == PH_SWAP);
    check("write_err", write_err, m_err);
`ifdef COEFF_READBACK_EN
    check("rb_coeff", rb_coeff, m_rb);
`endif
  endtask

  // Called at a negedge: drive one cycle, advance the model, sample at the next negedge.
  task automatic apply(input bit en, input bit we, input bit done, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input bit bnd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rba);
    clk_enable = en; write_enable = we; write_done = done; write_address = wa;
    coeffs_in = wd; sample_bound = bnd; rd_address = ra;
`ifdef COEFF_READBACK_EN
    rb_address = rba;
`endif
    if (en) model_step(we, done, wa, wd, bnd, ra, rba);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic [AW-1:0] ra);
    for (int i = 0; i < n; i++) apply(1, 0, 0, '0, '0, 0, ra, ra);
  endtask

  initial begin
    do_reset();

    // Load, request swap, swap on bound; filter sees the new value.
    apply(1, 1, 0, 6'd5, 16'h7FFF, 0, 6'd5, 6'd5);
    apply(1, 0, 1, '0, '0, 0, 6'd5, 6'd5);
    apply(1, 0, 0, '0, '0, 1, 6'd5, 6'd5);
    check("t1_swap_pulse", swap_done, 1);
    apply(1, 0, 0, '0, '0, 0, 6'd5, 6'd5);
    check("t1_rd_new", rd_coeff, 16'h7FFF);
    check("t1_bank_sel", bank_sel, 1);
    idle_cycles(DEPTH, 6'd5);
    check("t1_copy_done", busy, 0);

    // Shadow write without write_done leaves the filter view untouched.
    apply(1, 1, 0, 6'd3, 16'hFFFE, 0, 6'd3, 6'd3);
    apply(1, 0, 0, '0, '0, 0, 6'd3, 6'd3);
    check("t2_rd_unchanged", rd_coeff, 0);
`ifdef COEFF_READBACK_EN
    check("t2_rb_shadow", rb_coeff, 16'hFFFE);
`endif

    // Writes in PENDING/COPY are rejected; clk_enable=0 freezes the copy.
    apply(1, 0, 1, '0, '0, 0, 6'd3, 6'd3);
    apply(1, 1, 0, 6'd7, 16'h1234, 0, 6'd7, 6'd7);
    check("t3_err_pending", write_err, 1);
    apply(1, 0, 0, '0, '0, 1, 6'd3, 6'd3);
    apply(1, 0, 0, '0, '0, 0, 6'd3, 6'd3);
    check("t3_rd_swapped", rd_coeff, 16'hFFFE);
    for (int i = 0; i < 5; i++) apply(1, 1, 0, 6'(i), 16'hAAAA, 0, 6'd7, 6'd7);
    for (int i = 0; i < 10; i++) apply(0, 0, 0, '0, '0, 1, 6'd3, 6'd3);
    check("t4_frozen_busy", busy, 1);
    idle_cycles(DEPTH - 5 - 1, 6'd3);
    check("t4_still_busy", busy, 1);
    idle_cycles(1, 6'd3);
    check("t4_copy_end", busy, 0);

    // write_done with same-cycle bound, then reset while pending.
    do_reset();
    apply(1, 1, 1, 6'd9, 16'h0042, 1, 6'd9, 6'd9);
    apply(1, 0, 0, '0, '0, 0, 6'd9, 6'd9);
    check("t5_no_swap", bank_sel, 0);
    check("t5_pending", busy, 1);
    do_reset();
    check("t5_rst_busy", busy, 0);

    // Out-of-range write and read.
    apply(1, 1, 0, 6'd50, 16'h5555, 0, 6'd50, 6'd50);
    apply(1, 0, 0, '0, '0, 0, 6'd50, 6'd50);
    check("t6_err", write_err, 1);
    check("t6_rd_oor", rd_coeff, 0);
    do_reset();

    // Random traffic with occasional resets and enable stalls.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(599) == 0) begin
        do_reset();
      end else begin
        apply($urandom_range(99) < 85,
              $urandom_range(99) < 45,
              $urandom_range(99) < 4,
              6'($urandom_range(63)),
              16'($urandom),
              $urandom_range(99) < 10,
              6'($urandom_range(63)),
              6'($urandom_range(63)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
